// File: rtl/mem_pkg.sv
// Shared types and constants for the AXI4 memory slave.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_DATA,
        W_RESP
    } wr_state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    // Fibonacci feedback for taps 16,14,13,11 (bit indices 15,13,12,10).
    function automatic logic lfsr_feedback(input logic [15:0] s);
        return s[15] ^ s[13] ^ s[12] ^ s[10];
    endfunction

endpackage

// File: rtl/mem_lfsr.sv
// 16-bit Fibonacci LFSR used to draw per-transaction access delays.
// Latency: state advances one step per enabled cycle; reset loads LFSR_SEED.
// Backpressure: none; free-running while en is high.
//
// Ports: clk, rst (sync, active-high), en (advance), state (current value).
module mem_lfsr
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= {state[14:0], lfsr_feedback(state)};
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory slave with independent read and write engines.
// Latency: AR/AW handshake at edge k -> rvalid/wready after edge k+D+1; bvalid the edge after the last W beat.
// Backpressure: rdata/rlast held while rvalid&~rready; W waits for its AW; bvalid held until bready.
//
// Ports: clk, rst (sync, active-high); AW/W/B write channels; AR/R read channels.
// Build option: define MEM_RAND_DELAY_EN to draw D from an LFSR (low MAX_DELAY_LOG2 bits)
// instead of the fixed FIXED_LATENCY.
// The backing image is a word-addressed array of 2^MEM_AW 32-bit words; addresses
// above that range alias. npc_mem_read reads it; the write process updates it.
module axi_mem_slave
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int FIXED_LATENCY  = 1,
    parameter int MAX_DELAY_LOG2 = 5,
    parameter int MEM_AW         = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);

    localparam int                BYTES      = DATA_W / 8;
    localparam int                HALVES     = DATA_W / 32;
    localparam int                MEM_WORDS  = 1 << MEM_AW;
    localparam int                CNT_W      = (MAX_DELAY_LOG2 > 8) ? MAX_DELAY_LOG2 : 8;
    localparam logic [ADDR_W-1:0] BYTE_INC   = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));

    // ------------------------------------------------------------------
    // Backing image
    // ------------------------------------------------------------------
    logic [31:0] mem [MEM_WORDS];

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return MEM_AW'(a >> 2);
    endfunction

    // Wide beats are assembled from 32-bit words: low word at a, high at a+4.
    function automatic logic [DATA_W-1:0] npc_mem_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int h = 0; h < HALVES; h++) begin
            d[h*32 +: 32] = mem[word_idx(a + ADDR_W'(4 * h))];
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Access delay source
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] d_val;

`ifdef MEM_RAND_DELAY_EN
    logic [15:0] lfsr_q;

    mem_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr_q)
    );

    assign d_val = CNT_W'(lfsr_q[MAX_DELAY_LOG2-1:0]);
`else
    assign d_val = CNT_W'(FIXED_LATENCY);
`endif

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_t         rd_state, rd_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic [7:0]        rd_beat;
    logic [CNT_W-1:0]  rd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (arvalid)          rd_next = R_WAIT;
            R_WAIT:  if (rd_cnt == '0)     rd_next = R_DATA;
            R_DATA:  if (rready && rlast)  rd_next = R_IDLE;
            default:                       rd_next = R_IDLE;
        endcase
    end

    assign arready = (rd_state == R_IDLE);
    assign rvalid  = (rd_state == R_DATA);
    assign rresp   = RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
            rd_len  <= '0;
            rd_beat <= '0;
            rd_cnt  <= '0;
            rdata   <= '0;
            rlast   <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid) begin
                        rd_addr <= araddr & ALIGN_MASK;
                        rd_len  <= arlen;
                        rd_beat <= '0;
                        rd_cnt  <= d_val;
                    end
                end
                R_WAIT: begin
                    if (rd_cnt == '0) begin
                        rdata <= npc_mem_read(rd_addr);
                        rlast <= (rd_len == 8'd0);
                    end else begin
                        rd_cnt <= rd_cnt - CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rlast <= 1'b0;
                        end else begin
                            // Prefetch the next beat on the accepting edge: no bubble.
                            rd_addr <= rd_addr + BYTE_INC;
                            rd_beat <= rd_beat + 8'd1;
                            rdata   <= npc_mem_read(rd_addr + BYTE_INC);
                            rlast   <= ((rd_beat + 8'd1) == rd_len);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_t         wr_state, wr_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_len;
    logic [7:0]        wr_beat;
    logic [CNT_W-1:0]  wr_cnt;
    logic              wr_err;
    logic              w_fire;
    logic              wr_last_beat;
    logic              wlast_bad;

    assign w_fire       = (wr_state == W_DATA) && wvalid;
    assign wr_last_beat = (wr_beat == wr_len);
    assign wlast_bad    = (wlast != wr_last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (awvalid)                 wr_next = W_WAIT;
            W_WAIT:  if (wr_cnt == '0)            wr_next = W_DATA;
            W_DATA:  if (w_fire && wr_last_beat)  wr_next = W_RESP;
            W_RESP:  if (bready)                  wr_next = W_IDLE;
            default:                              wr_next = W_IDLE;
        endcase
    end

    assign awready = (wr_state == W_IDLE);
    assign wready  = (wr_state == W_DATA);
    assign bvalid  = (wr_state == W_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            wr_len  <= '0;
            wr_beat <= '0;
            wr_cnt  <= '0;
            wr_err  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (awvalid) begin
                        wr_addr <= awaddr & ALIGN_MASK;
                        wr_len  <= awlen;
                        wr_beat <= '0;
                        wr_cnt  <= d_val;
                        wr_err  <= 1'b0;
                    end
                end
                W_WAIT: begin
                    if (wr_cnt != '0) begin
                        wr_cnt <= wr_cnt - CNT_W'(1);
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        // A misplaced wlast is only reported; beat count follows awlen.
                        wr_addr <= wr_addr + BYTE_INC;
                        wr_beat <= wr_beat + 8'd1;
                        wr_err  <= wr_err | wlast_bad;
                        if (wr_last_beat) begin
                            bresp <= (wr_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bresp <= RESP_OKAY;
                    end
                end
                default: ;
            endcase
        end
    end

    // Image update. Reads elsewhere sample mem before these non-blocking
    // updates land, so a same-edge read returns the old contents. Byte lanes
    // with a clear strobe are untouched, so an all-zero half is a no-op.
    always_ff @(posedge clk) begin
        if (!rst && w_fire) begin
            for (int h = 0; h < HALVES; h++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[h*4 + b]) begin
                        mem[word_idx(wr_addr + ADDR_W'(4 * h))][b*8 +: 8] <= wdata[h*32 + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule
